ascon_permutation: RTL and testbench

Iterative Ascon permutation engine (p^a, 1–12 rounds) on the 320-bit Ascon state. It sits directly downstream of the OBI register controller, inside the ASCON core datapath. The core's mode sequencer hands it a state and a round count, then waits for a one-cycle completion pulse. By default it computes one round per clock; an optional build doubles throughput.

---
 rtl/ascon_permutation.sv | 162 ++++++++++++++++
 tb/tb_ascon_permutation.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation.sv
// ascon_permutation: iterative Ascon p^a engine on the 320-bit state.
// Word order: x0 = [319:256], x1 = [255:192], x2 = [191:128], x3 = [127:64], x4 = [63:0].
// Default build: one round per clock.
// Optional build macro ASCON_PERM_UNROLL2_EN: two cascaded rounds per clock,
// with a single round on the last edge when the round count is odd.
module ascon_permutation (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]   fsm_q, fsm_d;
    logic [3:0]   r_q, r_d;
    logic [319:0] state_q, state_d;
    logic         done_q, done_d;

    logic [3:0]   rounds_clamp_s;
    logic [319:0] round1_s;
`ifdef ASCON_PERM_UNROLL2_EN
    logic [319:0] round2_s;
`endif

    // 64-bit rotate right by a fixed amount
    function automatic logic [63:0] rotr64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One complete Ascon round (constant, S-box layer, linear layer) with constant index r
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        // round constant: high nibble counts down from 0xf, low nibble counts up
        x2 = x2 ^ {56'h0, 4'd15 - r, r};
        // bitsliced 5-bit S-box
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        // per-word linear diffusion
        x0 = x0 ^ rotr64(x0, 19) ^ rotr64(x0, 28);
        x1 = x1 ^ rotr64(x1, 61) ^ rotr64(x1, 39);
        x2 = x2 ^ rotr64(x2, 1)  ^ rotr64(x2, 6);
        x3 = x3 ^ rotr64(x3, 10) ^ rotr64(x3, 17);
        x4 = x4 ^ rotr64(x4, 7)  ^ rotr64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Clamp the requested round count to 0..12
    always_comb begin
        if (rounds_i > 4'd12) begin
            rounds_clamp_s = 4'd12;
        end else begin
            rounds_clamp_s = rounds_i;
        end
    end

    // Round datapath: round r, and in the unrolled build also round r+1
    always_comb begin
        round1_s = ascon_round(state_q, r_q);
`ifdef ASCON_PERM_UNROLL2_EN
        round2_s = ascon_round(round1_s, r_q + 4'd1);
`endif
    end

    // Next-state logic: accept a start while idle, step rounds while running
    always_comb begin
        fsm_d   = fsm_q;
        r_d     = r_q;
        state_d = state_q;
        done_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    if (rounds_clamp_s == 4'd0) begin
                        // nothing to compute: report completion straight away
                        done_d = 1'b1;
                    end else begin
                        r_d   = 4'd12 - rounds_clamp_s;
                        fsm_d = ST_RUN;
                    end
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef ASCON_PERM_UNROLL2_EN
                if (r_q == 4'd11) begin
                    // odd round count: only the final round is left
                    state_d = round1_s;
                    r_d     = 4'd12;
                end else begin
                    state_d = round2_s;
                    r_d     = r_q + 4'd2;
                end
`else
                state_d = round1_s;
                r_d     = r_q + 4'd1;
`endif
                if (r_d >= 4'd12) begin
                    fsm_d  = ST_IDLE;
                    done_d = 1'b1;
                    r_d    = 4'd0;
                end else begin
                    fsm_d  = ST_RUN;
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                r_d     = 4'd0;
                state_d = 320'd0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State, round index, FSM and completion pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= ST_IDLE;
            r_q     <= 4'd0;
            state_q <= 320'd0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            r_q     <= r_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == ST_RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Self-checking bench for ascon_permutation with a word-array reference model.
module tb_ascon_permutation;

    logic         clk_i;
    logic         rst_ni;
    logic         start_i;
    logic [3:0]   rounds_i;
    logic [319:0] state_i;
    logic [319:0] state_o;
    logic         busy_o;
    logic         done_o;

    int checks;
    int failures;

    ascon_permutation dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .rounds_i (rounds_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v};
        return d[n +: 64];
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int a);
        logic [63:0] x [5];
        logic [63:0] t [5];
        int rot_a [5] = '{19, 61, 1, 10, 7};
        int rot_b [5] = '{28, 39, 6, 17, 41};
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 12 - a; r < 12; r++) begin
            x[2] ^= 64'((15 - r) * 16 + r);
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
            for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            for (int i = 0; i < 5; i++) x[i] = x[i] ^ m_ror(x[i], rot_a[i]) ^ m_ror(x[i], rot_b[i]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int clamp(input int r);
        return (r > 12) ? 12 : r;
    endfunction

    function automatic int latency(input int a);
`ifdef ASCON_PERM_UNROLL2_EN
        return (a + 1) / 2;
`else
        return a;
`endif
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    logic [319:0] last_result;

    // Run one permutation; checks latency, busy during the run, result and done pulse width
    task automatic do_perm(input string tag, input logic [319:0] st, input logic [3:0] rnds);
        int a, lat, n;
        logic [319:0] exp;
        a   = clamp(int'(rnds));
        lat = latency(a);
        exp = model_perm(st, a);
        @(negedge clk_i);
        start_i  = 1'b1;
        state_i  = st;
        rounds_i = rnds;
        @(negedge clk_i);
        start_i  = 1'b0;
        state_i  = rand320();
        rounds_i = 4'($urandom_range(0, 15));
        n = 0;
        if (lat > 0) check_eq({tag, "_busy"}, 320'(busy_o), 320'd1);
        while (!done_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        check_eq({tag, "_lat"}, 320'(n), 320'(lat));
        check_eq({tag, "_state"}, state_o, exp);
        check_eq({tag, "_idle"}, 320'(busy_o), 320'd0);
        last_result = state_o;
        @(negedge clk_i);
        check_eq({tag, "_pulse"}, 320'(done_o), 320'd0);
    endtask

    logic [319:0] st_a, st_b, res12, c_st;
    logic [63:0]  c;
    int n, ndone;

    initial begin
        checks = 0; failures = 0;
        rst_ni = 1'b0; start_i = 1'b0; rounds_i = 4'd0; state_i = 320'd0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_state", state_o, 320'd0);
        check_eq("rst_busy", 320'(busy_o), 320'd0);
        check_eq("rst_done", 320'(done_o), 320'd0);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_eq("idle_busy", 320'(busy_o), 320'd0);
            check_eq("idle_done", 320'(done_o), 320'd0);
        end

        // single round on zero state, against closed-form expectation
        c = 64'h4b;
        c_st = {c ^ m_ror(c, 19) ^ m_ror(c, 28),
                c ^ m_ror(c, 61) ^ m_ror(c, 39),
                ~(c ^ m_ror(c, 1) ^ m_ror(c, 6)),
                c ^ m_ror(c, 10) ^ m_ror(c, 17),
                64'd0};
        do_perm("p1_zero", 320'd0, 4'd1);
        check_eq("p1_closed", last_result, c_st);

        // Ascon-128 initial state through p12
        st_a = {64'h80400c0600000000, 64'd0, 64'd0, 64'd0, 64'd0};
        do_perm("p12_init", st_a, 4'd12);
        res12 = last_result;
        do_perm("p15_clamp", st_a, 4'd15);
        check_eq("clamp_same", last_result, res12);

        // random states at several round counts
        for (int k = 0; k < 6; k++) begin
            do_perm("p6_rand", rand320(), 4'd6);
            do_perm("p8_rand", rand320(), 4'd8);
            do_perm("prand", rand320(), 4'($urandom_range(1, 15)));
        end
        do_perm("p3_rand", rand320(), 4'd3);

        // zero rounds: done on the accept edge, state passes through
        st_b = rand320();
        do_perm("p0", st_b, 4'd0);
        check_eq("p0_pass", last_result, st_b);

        // start while busy is ignored; start in the done cycle is accepted
        st_a = rand320();
        st_b = rand320();
        @(negedge clk_i);
        start_i = 1'b1; state_i = st_a; rounds_i = 4'd12;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0; ndone = 0;
        while (ndone == 0 && n < 30) begin
            if (n == 2) begin
                start_i = 1'b1; state_i = rand320(); rounds_i = 4'd1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            n++;
            if (done_o) ndone++;
        end
        check_eq("busy_ign_lat", 320'(n), 320'(latency(12)));
        check_eq("busy_ign_state", state_o, model_perm(st_a, 12));
        start_i = 1'b1; state_i = st_b; rounds_i = 4'd6;
        @(negedge clk_i);
        start_i = 1'b0;
        check_eq("b2b_busy", 320'(busy_o), 320'd1);
        n = 0;
        while (!done_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("b2b_lat", 320'(n), 320'(latency(6)));
        check_eq("b2b_state", state_o, model_perm(st_b, 6));

        // reset in the middle of a p12
        @(negedge clk_i);
        start_i = 1'b1; state_i = rand320(); rounds_i = 4'd12;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_eq("mrst_state", state_o, 320'd0);
        check_eq("mrst_busy", 320'(busy_o), 320'd0);
        check_eq("mrst_done", 320'(done_o), 320'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) ndone++;
        end
        check_eq("mrst_quiet", 320'(ndone), 320'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
